// File: rtl/scope_vga_pkg.sv
// scope_vga_pkg: constants and colour helpers shared by the scope VGA layers.
package scope_vga_pkg;

  // Default visible raster.
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Smallest usable division pitch; finer grids turn into a grey wash.
  localparam logic [7:0] MIN_DIV_PX = 8'd4;

  // Colour selected for a pixel; expanded per channel by chan_level().
  typedef enum logic [1:0] {
    COL_BLACK  = 2'd0,
    COL_GREY   = 2'd1,
    COL_YELLOW = 2'd2,
    COL_WHITE  = 2'd3
  } col_e;

  // Per-channel intensity: off, MSB only (mid-grey), all ones.
  typedef enum logic [1:0] {
    LVL_ZERO = 2'd0,
    LVL_HALF = 2'd1,
    LVL_FULL = 2'd2
  } lvl_e;

  // Channel index: 0 = red, 1 = green, 2 = blue.
  function automatic lvl_e chan_level(input col_e col, input int ch);
    lvl_e lvl;
    case (col)
      COL_WHITE:  lvl = LVL_FULL;
      COL_GREY:   lvl = LVL_HALF;
      COL_YELLOW: lvl = (ch == 2) ? LVL_ZERO : LVL_FULL;
      default:    lvl = LVL_ZERO;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/graticule_phase_ctr.sv
// graticule_phase_ctr: reloadable wrapping phase counter. o_phase is the phase
// that applies to the current cycle (reload/step already folded in), so the
// caller can use it in the same cycle as the pixel it belongs to.
module graticule_phase_ctr
  import scope_vga_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_reload,
  input  logic         i_step,
  input  logic [W-1:0] i_modulus,
  output logic [W-1:0] o_phase
);

  logic [W-1:0] r_phase;
  logic [W-1:0] w_phase_next;

  // Reload wins over step; >= keeps the wrap safe if the modulus shrinks.
  always_comb begin
    w_phase_next = r_phase;
    if (i_reload) begin
      w_phase_next = '0;
    end else if (i_step) begin
      if (r_phase >= (i_modulus - W'(1))) begin
        w_phase_next = '0;
      end else begin
        w_phase_next = r_phase + W'(1);
      end
    end
  end

  assign o_phase = w_phase_next;

  // Hold the phase of the current cycle for the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_next;
    end
  end

endmodule

// File: rtl/scope_graticule_gen.sv
// scope_graticule_gen: draws the plot grid, both axes and a horizontal marker
// line into the VGA colour stream, one register stage after x/y/video_on.
// Optional feature macro: SCOPE_MARKER_BLINK_EN (marker blinks every
// BLINK_FRAMES frames when defined; steady marker otherwise).
module scope_graticule_gen
  import scope_vga_pkg::*;
#(
  parameter int COLOR_W      = 3,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int PLOT_X0      = 160,
  parameter int AXIS_Y       = 240,
  parameter int DIV_DEFAULT  = 40,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               video_on,
  input  logic               frame_start,
  input  logic [7:0]         cfg_div_px,
  input  logic               marker_en,
  input  logic [9:0]         marker_y,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               in_plot
);

  localparam logic [COLOR_W-1:0] CH_FULL = '1;
  localparam logic [COLOR_W-1:0] CH_HALF = COLOR_W'(1 << (COLOR_W - 1));

  // Frame state
  logic [7:0]  r_div_shadow;
  logic [9:0]  r_y_prev;
  logic        r_grid_sync;

  // Output stage
  logic [3*COLOR_W-1:0] r_rgb;
  logic                 r_in_plot;
  logic                 r_video_on;

  // Combinational pixel decode
  logic [7:0]           w_div_clamped;
  logic                 w_line_start;
  logic                 w_y_reload;
  logic                 w_y_step;
  logic                 w_x_reload;
  logic [7:0]           w_x_phase;
  logic [7:0]           w_y_phase;
  logic                 w_grid_sync;
  logic                 w_x_in;
  logic                 w_in_plot;
  logic                 w_blink_on;
  logic                 w_marker_hit;
  logic                 w_axis_hit;
  logic                 w_grid_hit;
  col_e                 w_col;
  logic [3*COLOR_W-1:0] w_rgb_next;

  assign w_div_clamped = (cfg_div_px < MIN_DIV_PX) ? MIN_DIV_PX : cfg_div_px;

  // A row change is the line start; row 0 re-aligns the vertical phase.
  assign w_line_start = (y != r_y_prev);
  assign w_y_reload   = w_line_start && (y == 10'd0);
  assign w_y_step     = w_line_start && (y != 10'd0);
  assign w_x_reload   = (x == 10'(PLOT_X0));

  graticule_phase_ctr #(.W(8)) u_x_phase (
    .clk       (clk),
    .reset     (reset),
    .i_reload  (w_x_reload),
    .i_step    (1'b1),
    .i_modulus (r_div_shadow),
    .o_phase   (w_x_phase)
  );

  graticule_phase_ctr #(.W(8)) u_y_phase (
    .clk       (clk),
    .reset     (reset),
    .i_reload  (w_y_reload),
    .i_step    (w_y_step),
    .i_modulus (r_div_shadow),
    .o_phase   (w_y_phase)
  );

  // The row-0 line start already counts as synced for its own pixels.
  assign w_grid_sync = r_grid_sync | w_y_reload;

  assign w_x_in    = (x >= 10'(PLOT_X0));
  assign w_in_plot = w_x_in && (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));

`ifdef SCOPE_MARKER_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BC_W-1:0] r_blink_cnt;
  logic            r_blink_on;

  // Count frames; toggle marker visibility every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BC_W'(1);
      end
    end
  end

  assign w_blink_on = r_blink_on;
`else
  assign w_blink_on = 1'b1;
`endif

  assign w_marker_hit = marker_en && w_blink_on && (y == marker_y) &&
                        (marker_y < 10'(V_ACTIVE)) && !x[0];
  assign w_axis_hit   = (x == 10'(PLOT_X0)) || (y == 10'(AXIS_Y));
  assign w_grid_hit   = w_grid_sync &&
                        (((w_x_phase == 8'd0) && !y[0]) ||
                         ((w_y_phase == 8'd0) && !x[0]));

  // Layer priority: marker, axis, grid dot, background; nothing left of the plot.
  always_comb begin
    w_col = COL_BLACK;
    if (w_x_in) begin
      if (w_marker_hit) begin
        w_col = COL_YELLOW;
      end else if (w_axis_hit) begin
        w_col = COL_WHITE;
      end else if (w_grid_hit) begin
        w_col = COL_GREY;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      lvl_e w_lvl;
      assign w_lvl = chan_level(w_col, gi);
      assign w_rgb_next[gi*COLOR_W +: COLOR_W] =
          (w_lvl == LVL_FULL) ? CH_FULL :
          (w_lvl == LVL_HALF) ? CH_HALF : '0;
    end
  endgenerate

  // Frame-level state: pitch shadow, previous row, grid sync flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_shadow <= 8'(DIV_DEFAULT);
      // All ones so the first row seen after reset registers as a line start.
      r_y_prev     <= '1;
      r_grid_sync  <= 1'b0;
    end else begin
      if (frame_start) begin
        r_div_shadow <= w_div_clamped;
      end
      r_y_prev <= y;
      if (w_y_reload) begin
        r_grid_sync <= 1'b1;
      end
    end
  end

  // Output register stage, with video_on delayed alongside the colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb      <= '0;
      r_in_plot  <= 1'b0;
      r_video_on <= 1'b0;
    end else begin
      r_rgb      <= w_rgb_next;
      r_in_plot  <= w_in_plot;
      r_video_on <= video_on;
    end
  end

  assign red     = r_video_on ? r_rgb[0*COLOR_W +: COLOR_W] : '0;
  assign green   = r_video_on ? r_rgb[1*COLOR_W +: COLOR_W] : '0;
  assign blue    = r_video_on ? r_rgb[2*COLOR_W +: COLOR_W] : '0;
  assign in_plot = r_video_on && r_in_plot;

endmodule

// File: tb/tb_scope_graticule_gen.sv
// tb_scope_graticule_gen: directed checkpoints on a compressed raster
// (short lines around the plot origin) with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_scope_graticule_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       frame_start;
  logic [7:0] cfg_div_px;
  logic       marker_en;
  logic [9:0] marker_y;
  logic [2:0] red;
  logic [2:0] green;
  logic [2:0] blue;
  logic       in_plot;

  always #5 clk = ~clk;

  scope_graticule_gen #(
    .COLOR_W      (3),
    .H_ACTIVE     (640),
    .V_ACTIVE     (480),
    .PLOT_X0      (160),
    .AXIS_Y       (240),
    .DIV_DEFAULT  (40),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .video_on    (video_on),
    .frame_start (frame_start),
    .cfg_div_px  (cfg_div_px),
    .marker_en   (marker_en),
    .marker_y    (marker_y),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .in_plot     (in_plot)
  );

  // Expected colours as {red, green, blue}.
  localparam logic [8:0] BLK = 9'o000;
  localparam logic [8:0] GRY = 9'o444;
  localparam logic [8:0] WHT = 9'o777;
  localparam logic [8:0] YEL = 9'o770;

`ifdef SCOPE_MARKER_BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif

  typedef struct {
    int         px;
    int         py;
    logic [8:0] rgb;
    bit         chk_ip;
    bit         ip;
  } exp_t;

  exp_t pend[$];   // checkpoints waiting for their pixel to be driven
  exp_t sb_q[$];   // expectations for pixels already driven

  int n_vec = 0;
  int n_err = 0;
  bit chk_now = 1'b0;
  bit chk_d = 1'b0;
  int rst_x = -1;

  // ---------------- monitor ----------------
  always @(posedge clk) chk_d <= chk_now;

  always @(negedge clk) begin
    if (chk_d) begin
      exp_t e;
      logic [8:0] got;
      n_vec++;
      got = {red, green, blue};
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: output tagged but no expectation queued");
      end else begin
        e = sb_q.pop_front();
        if ((got !== e.rgb) || (e.chk_ip && (in_plot !== e.ip))) begin
          n_err++;
          $display("FAIL pix(%0d,%0d): got rgb=%o in_plot=%b, expected rgb=%o in_plot=%b%s",
                   e.px, e.py, got, in_plot, e.rgb, e.ip, e.chk_ip ? "" : " (in_plot not checked)");
        end else begin
          $display("ok   pix(%0d,%0d): rgb=%o in_plot=%b", e.px, e.py, got, in_plot);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic exp_px(input int px, input int py, input logic [8:0] rgb,
                        input bit ci, input bit ip);
    exp_t e;
    e.px = px; e.py = py; e.rgb = rgb; e.chk_ip = ci; e.ip = ip;
    pend.push_back(e);
  endtask

  task automatic pix(input int px, input int py, input bit vo, input bit rst);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    video_on = vo;
    frame_start = 1'b0;
    reset = rst;
    chk_now = 1'b0;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].px == px && pend[i].py == py) begin
        sb_q.push_back(pend[i]);
        pend.delete(i);
        chk_now = 1'b1;
        break;
      end
    end
  endtask

  task automatic line(input int py, input int x0, input int x1);
    for (int xi = x0; xi <= x1; xi++) pix(xi, py, 1'b1, (xi == rst_x));
    for (int b = 0; b < 4; b++) pix(640 + b, py, 1'b0, 1'b0);
  endtask

  // frame_start (with the new pitch presented in the same cycle), then rows 0..nrows-1.
  task automatic frame(input bit fs, input int nrows, input int cfg);
    if (fs) begin
      @(negedge clk);
      x = 10'd700;
      video_on = 1'b0;
      reset = 1'b0;
      frame_start = 1'b1;
      cfg_div_px = 8'(cfg);
      chk_now = 1'b0;
    end
    for (int r = 0; r < nrows; r++) line(r, 156, 205);
  endtask

  task automatic do_reset();
    pix(700, int'(y), 1'b0, 1'b1);
    pix(700, int'(y), 1'b0, 1'b1);
  endtask

  task automatic flush_pend();
    while (pend.size() != 0) begin
      exp_t e;
      e = pend.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL unreached pix(%0d,%0d): got nothing, expected rgb=%o", e.px, e.py, e.rgb);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; x = '0; y = '0; video_on = 1'b0; frame_start = 1'b0;
    cfg_div_px = 8'd40; marker_en = 1'b0; marker_y = '0;

    // Reset state: black and out of plot even on an axis pixel.
    exp_px(170, 240, BLK, 1, 0);
    pix(170, 240, 1'b1, 1'b1);
    pix(170, 240, 1'b1, 1'b1);

    // Frame A: pitch 40.
    exp_px(162, 0, GRY, 1, 1);
    exp_px(171, 0, BLK, 1, 1);
    exp_px(158, 2, BLK, 1, 0);
    exp_px(161, 2, BLK, 1, 1);
    exp_px(200, 2, GRY, 1, 1);
    exp_px(201, 3, BLK, 1, 1);
    exp_px(160, 17, WHT, 1, 1);
    exp_px(202, 40, GRY, 1, 1);
    exp_px(203, 40, BLK, 1, 1);
    frame(1, 41, 40);
    exp_px(159, 240, BLK, 1, 0);
    exp_px(300, 240, WHT, 1, 1);
    line(240, 156, 305);
    exp_px(160, 240, BLK, 1, 0);          // video_on low blanks the axis
    pix(160, 240, 1'b0, 1'b0);
    flush_pend();

    // Frame B: pitch change requested at row 100 must wait for frame_start.
    exp_px(180, 2, BLK, 1, 1);
    exp_px(180, 100, BLK, 1, 1);
    exp_px(200, 100, GRY, 1, 1);
    @(negedge clk);
    x = 10'd700; video_on = 1'b0; frame_start = 1'b1; chk_now = 1'b0;
    for (int r = 0; r < 102; r++) begin
      if (r == 100) cfg_div_px = 8'd20;
      line(r, 156, 205);
    end
    flush_pend();

    // Frame C: pitch 20 now live.
    exp_px(170, 2, BLK, 1, 1);
    exp_px(180, 2, GRY, 1, 1);
    exp_px(190, 2, BLK, 1, 1);
    exp_px(200, 2, GRY, 1, 1);
    frame(1, 4, 20);
    flush_pend();

    // Frames D/E: pitch 1 then 0 clamp to 4.
    exp_px(164, 2, GRY, 1, 1);
    exp_px(165, 2, BLK, 1, 1);
    exp_px(166, 2, BLK, 1, 1);
    exp_px(162, 4, GRY, 1, 1);
    exp_px(163, 4, BLK, 1, 1);
    frame(1, 5, 1);
    exp_px(164, 2, GRY, 1, 1);
    exp_px(166, 2, BLK, 1, 1);
    exp_px(168, 2, GRY, 1, 1);
    frame(1, 3, 0);
    flush_pend();

    // Marker at row 300 (fresh reset so blink is in its visible phase).
    do_reset();
    marker_en = 1'b1; marker_y = 10'd300;
    frame(1, 3, 40);
    exp_px(160, 300, YEL, 1, 1);          // marker outranks the axis
    exp_px(162, 300, YEL, 1, 1);
    exp_px(163, 300, BLK, 1, 1);
    line(300, 156, 205);
    marker_y = 10'd500;
    exp_px(160, 500, WHT, 0, 0);          // off-screen marker row is ignored
    pix(160, 500, 1'b1, 1'b0);
    marker_y = 10'd300; marker_en = 1'b0;
    exp_px(160, 300, WHT, 1, 1);
    exp_px(162, 300, BLK, 1, 1);
    line(300, 156, 205);
    flush_pend();

    // Blink: frames 0..4 after reset, marker on row 2.
    do_reset();
    marker_en = 1'b1; marker_y = 10'd2;
    for (int f = 0; f < 5; f++) begin
      bit vis;
      vis = !BLINK_BUILT || (f < 2) || (f == 4);
      exp_px(160, 2, vis ? YEL : WHT, 1, 1);
      exp_px(162, 2, vis ? YEL : BLK, 1, 1);
      frame(f != 0, 3, 40);
      flush_pend();
    end
    marker_en = 1'b0;

    // Reset in mid-frame on the axis row.
    frame(1, 3, 40);
    exp_px(160, 240, WHT, 1, 1);
    exp_px(164, 240, BLK, 1, 0);
    exp_px(165, 240, WHT, 1, 1);
    rst_x = 164;
    line(240, 156, 205);
    rst_x = -1;
    exp_px(160, 250, WHT, 1, 1);
    exp_px(200, 250, BLK, 1, 1);          // dots held off until row 0
    line(250, 156, 205);
    exp_px(162, 0, GRY, 1, 1);
    exp_px(200, 2, GRY, 1, 1);
    frame(1, 3, 40);

    // Drain.
    for (int i = 0; i < 4; i++) pix(700, int'(y), 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d expectations outstanding, expected 0", sb_q.size());
    end
    flush_pend();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
